// File: rtl/decoder_pkg.sv
// Shared types and helpers for the decoder_n_seq family: FSM state encoding,
// legal index-width range, and the binary-to-one-hot helper.
package decoder_pkg;

    localparam int N_IN_MIN  = 1;
    localparam int N_IN_MAX  = 8;
    localparam int OUT_W_MAX = 1 << N_IN_MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    // Callers truncate the result to their own OUT_W.
    function automatic logic [OUT_W_MAX-1:0] onehot(input logic [N_IN_MAX-1:0] idx);
        logic [OUT_W_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_hold_cnt.sv
// Loadable down-counter with a zero flag; it paces both single-decode holds
// and each scan position.
module decoder_hold_cnt #(
    parameter int HOLD_CYCLES = 1,
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Load wins over decrement; the counter parks at zero rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (dec && !zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/decoder_n_seq.sv
// Registered N_IN-to-2**N_IN one-hot decoder with a programmable hold time,
// en/ready input handshake and a scan mode that walks every output position.
module decoder_n_seq
    import decoder_pkg::*;
#(
    parameter int N_IN        = 3,
    parameter int HOLD_CYCLES = 1,
    localparam int OUT_W = 1 << N_IN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  din,
    input  logic             en,
    input  logic             mode,
    output logic             ready,
    output logic [OUT_W-1:0] dout,
    output logic             vld,
    output logic             scan_done
);

    if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
        $error("decoder_n_seq: N_IN=%0d outside legal range %0d..%0d", N_IN, N_IN_MIN, N_IN_MAX);
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("decoder_n_seq: HOLD_CYCLES=%0d must be at least 1", HOLD_CYCLES);
    end

    localparam logic [N_IN-1:0] STEP_LAST = N_IN'(OUT_W - 1);

    // Handshake: a transfer happens on a rising clk edge where en and ready are
    // both high; ready depends only on registered state, never on en/din/mode.
    state_t           state_q, state_d;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             done_q, done_d;
    logic [N_IN-1:0]  step_q, step_d;
    logic             hc_load, hc_dec, hc_zero;
    logic             ready_int;
    logic             xfer;

    decoder_hold_cnt #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (hc_load),
        .dec  (hc_dec),
        .zero (hc_zero)
    );

    assign ready_int = (state_q == IDLE) || (state_q == HOLD && hc_zero);
    assign xfer      = en && ready_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        step_d  = step_q;
        hc_load = 1'b0;
        hc_dec  = 1'b0;

        // din is only looked at on a transfer, so garbage on it elsewhere is inert.
        if (xfer) begin
            dout_d  = OUT_W'(onehot(N_IN_MAX'(din)));
            vld_d   = 1'b1;
            hc_load = 1'b1;
            if (mode) begin
                state_d = SCAN;
                step_d  = '0;
            end else begin
                state_d = HOLD;
            end
        end else begin
            case (state_q)
                HOLD: begin
                    if (!hc_zero) begin
                        hc_dec = 1'b1;
                    end else begin
                        dout_d  = '0;
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                SCAN: begin
                    if (!hc_zero) begin
                        hc_dec = 1'b1;
                    end else if (step_q != STEP_LAST) begin
                        dout_d  = {dout_q[OUT_W-2:0], dout_q[OUT_W-1]};
                        step_d  = step_q + N_IN'(1);
                        hc_load = 1'b1;
                    end else begin
                        dout_d  = '0;
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready     = ready_int;
    assign dout      = dout_q;
    assign vld       = vld_q;
    assign scan_done = done_q;

endmodule

// File: tb/tb_decoder_n_seq.sv
// Self-checking bench for decoder_n_seq: directed vector tables on N_IN=3
// builds plus randomized scoreboard runs on N_IN=1 and N_IN=8 builds.
module tb_decoder_n_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Shared stimulus for the three N_IN=3 builds (only the selected one is checked).
    logic       en3 = 1'b0;
    logic [2:0] din3 = '0;
    logic       mode3 = 1'b0;
    logic       rdy_a, vld_a, done_a;
    logic [7:0] dout_a;
    logic       rdy_b, vld_b, done_b;
    logic [7:0] dout_b;
    logic       rdy_c, vld_c, done_c;
    logic [7:0] dout_c;

    logic         en_r1 = 1'b0, mode_r1 = 1'b0;
    logic [0:0]   din_r1 = '0;
    logic         rdy_r1, vld_r1, done_r1;
    logic [1:0]   dout_r1;
    logic         en_r8 = 1'b0, mode_r8 = 1'b0;
    logic [7:0]   din_r8 = '0;
    logic         rdy_r8, vld_r8, done_r8;
    logic [255:0] dout_r8;

    decoder_n_seq #(.N_IN(3), .HOLD_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .din(din3), .en(en3), .mode(mode3),
        .ready(rdy_a), .dout(dout_a), .vld(vld_a), .scan_done(done_a));
    decoder_n_seq #(.N_IN(3), .HOLD_CYCLES(2)) u_b (
        .clk(clk), .rst(rst), .din(din3), .en(en3), .mode(mode3),
        .ready(rdy_b), .dout(dout_b), .vld(vld_b), .scan_done(done_b));
    decoder_n_seq #(.N_IN(3), .HOLD_CYCLES(4)) u_c (
        .clk(clk), .rst(rst), .din(din3), .en(en3), .mode(mode3),
        .ready(rdy_c), .dout(dout_c), .vld(vld_c), .scan_done(done_c));
    decoder_n_seq #(.N_IN(1), .HOLD_CYCLES(2)) u_r1 (
        .clk(clk), .rst(rst), .din(din_r1), .en(en_r1), .mode(mode_r1),
        .ready(rdy_r1), .dout(dout_r1), .vld(vld_r1), .scan_done(done_r1));
    decoder_n_seq #(.N_IN(8), .HOLD_CYCLES(1)) u_r8 (
        .clk(clk), .rst(rst), .din(din_r8), .en(en_r8), .mode(mode_r8),
        .ready(rdy_r8), .dout(dout_r8), .vld(vld_r8), .scan_done(done_r8));

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic get_out(input int sel, output logic [7:0] d, output logic r, output logic v,
                           output logic dn);
        case (sel)
            1:       begin d = dout_a; r = rdy_a; v = vld_a; dn = done_a; end
            2:       begin d = dout_b; r = rdy_b; v = vld_b; dn = done_b; end
            default: begin d = dout_c; r = rdy_c; v = vld_c; dn = done_c; end
        endcase
    endtask

    // ---------------- driver tasks ----------------
    // Entered and left at posedge+1; checks reset values while rst is high.
    task automatic do_reset();
        en3 = 1'b0; en_r1 = 1'b0; en_r8 = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_ready_a", 256'(rdy_a), 256'(1));
        chk("rst_dout_a", 256'(dout_a), 256'(0));
        chk("rst_vld_b", 256'(vld_b), 256'(0));
        chk("rst_ready_c", 256'(rdy_c), 256'(1));
        chk("rst_done_a", 256'(done_a), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic step3(input logic e, input logic [2:0] d, input logic m);
        en3 = e; din3 = d; mode3 = m;
        @(posedge clk); #1;
        en3 = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       do_rst;
        int         sel;
        logic       en;
        logic [2:0] din;
        logic       mode;
        logic [7:0] dout;
        logic       rdy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rs, input int sel, input logic e, input logic [2:0] d,
                       input logic m, input logic [7:0] xd, input logic xr, input logic xdn);
        vec_t v;
        v.do_rst = rs; v.sel = sel; v.en = e; v.din = d; v.mode = m;
        v.dout = xd; v.rdy = xr; v.done = xdn;
        vecs.push_back(v);
    endtask

    // ---------------- scoreboard ----------------
    // Directed: {dout, vld, ready, scan_done} per cycle.
    logic [10:0]  dir_q[$];
    // Random: {dout, kind, scan_done} per future cycle.
    localparam logic [1:0] K_IDLE = 2'd0, K_HOLD = 2'd1, K_SCAN = 2'd2;
    logic [258:0] exp_q[$];

    task automatic run_rand(input int sel, input int ncyc);
        int           out_w, hold, scan_len, d;
        logic         e, m, model_rdy, dut_rdy, dut_v, dut_dn;
        logic [1:0]   cur_kind;
        logic [255:0] oh, dut_d;
        logic [258:0] item;
        out_w = (sel == 0) ? 2 : 256;
        hold  = (sel == 0) ? 2 : 1;
        cur_kind = K_IDLE;
        scan_len = 0;
        exp_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            e = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 4) == 0);
            d = $urandom_range(0, out_w - 1);
            if (sel == 0) begin
                en_r1 = e; din_r1 = 1'(d); mode_r1 = m; dut_rdy = rdy_r1;
            end else begin
                en_r8 = e; din_r8 = 8'(d); mode_r8 = m; dut_rdy = rdy_r8;
            end
            model_rdy = (cur_kind == K_IDLE) || (cur_kind == K_HOLD && exp_q.size() == 0);
            chk("rand_ready", 256'(dut_rdy), 256'(model_rdy));
            if (e && model_rdy) begin
                if (!m) begin
                    oh = 256'(1) << d;
                    for (int h = 0; h < hold; h++) exp_q.push_back({oh, K_HOLD, 1'b0});
                end else begin
                    scan_len = 0;
                    for (int p = 0; p < out_w; p++) begin
                        oh = 256'(1) << ((d + p) % out_w);
                        for (int h = 0; h < hold; h++) exp_q.push_back({oh, K_SCAN, 1'b0});
                    end
                    exp_q.push_back({256'(0), K_IDLE, 1'b1});
                end
            end
            @(posedge clk); #1;
            item = (exp_q.size() > 0) ? exp_q.pop_front() : {256'(0), K_IDLE, 1'b0};
            cur_kind = item[2:1];
            if (sel == 0) begin
                dut_d = 256'(dout_r1); dut_v = vld_r1; dut_dn = done_r1;
            end else begin
                dut_d = dout_r8; dut_v = vld_r8; dut_dn = done_r8;
            end
            chk("rand_dout", dut_d, item[258:3]);
            chk("rand_vld", 256'(dut_v), 256'(|item[258:3]));
            chk("rand_done", 256'(dut_dn), 256'(item[0]));
            chk("rand_onehot", 256'($onehot0(dut_d)), 256'(1));
            chk("rand_vld_or", 256'(dut_v), 256'(|dut_d));
            if (dut_v) scan_len++;
            if (dut_dn) chk("rand_scan_len", 256'(scan_len), 256'(out_w * hold));
        end
        en_r1 = 1'b0; en_r8 = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]  ad;
        logic        ar, av, adn;
        logic [10:0] ex;

        // Single decode, HOLD=1
        add(1, 1, 0, 0, 0, 8'h00, 1, 0);
        add(0, 1, 1, 5, 0, 8'h20, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 1, 0);
        // Back-to-back decodes, HOLD=2, en held high
        add(1, 2, 0, 0, 0, 8'h00, 1, 0);
        add(0, 2, 1, 0, 0, 8'h01, 0, 0);
        add(0, 2, 1, 3, 0, 8'h01, 1, 0);
        add(0, 2, 1, 3, 0, 8'h08, 0, 0);
        add(0, 2, 1, 7, 0, 8'h08, 1, 0);
        add(0, 2, 1, 7, 0, 8'h80, 0, 0);
        add(0, 2, 0, 7, 0, 8'h80, 1, 0);
        add(0, 2, 0, 0, 0, 8'h00, 1, 0);
        // Scan from 6, HOLD=1
        add(1, 1, 0, 0, 0, 8'h00, 1, 0);
        add(0, 1, 1, 6, 1, 8'h40, 0, 0);
        add(0, 1, 0, 0, 0, 8'h80, 0, 0);
        add(0, 1, 0, 0, 0, 8'h01, 0, 0);
        add(0, 1, 0, 0, 0, 8'h02, 0, 0);
        add(0, 1, 0, 0, 0, 8'h04, 0, 0);
        add(0, 1, 0, 0, 0, 8'h08, 0, 0);
        add(0, 1, 0, 0, 0, 8'h10, 0, 0);
        add(0, 1, 0, 0, 0, 8'h20, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 1, 1);
        add(0, 1, 0, 0, 0, 8'h00, 1, 0);
        // en during a scan is ignored; accepted once ready returns
        add(1, 1, 0, 0, 0, 8'h00, 1, 0);
        add(0, 1, 1, 6, 1, 8'h40, 0, 0);
        add(0, 1, 1, 2, 0, 8'h80, 0, 0);
        add(0, 1, 1, 2, 0, 8'h01, 0, 0);
        add(0, 1, 1, 2, 0, 8'h02, 0, 0);
        add(0, 1, 0, 2, 0, 8'h04, 0, 0);
        add(0, 1, 0, 2, 0, 8'h08, 0, 0);
        add(0, 1, 0, 2, 0, 8'h10, 0, 0);
        add(0, 1, 0, 2, 0, 8'h20, 0, 0);
        add(0, 1, 1, 2, 0, 8'h00, 1, 1);
        add(0, 1, 1, 2, 0, 8'h04, 1, 0);
        add(0, 1, 0, 0, 0, 8'h00, 1, 0);

        #1;
        foreach (vecs[i]) begin
            if (vecs[i].do_rst) begin
                do_reset();
                continue;
            end
            en3 = vecs[i].en; din3 = vecs[i].din; mode3 = vecs[i].mode;
            dir_q.push_back({vecs[i].dout, |vecs[i].dout, vecs[i].rdy, vecs[i].done});
            @(posedge clk); #1;
            en3 = 1'b0;
            get_out(vecs[i].sel, ad, ar, av, adn);
            ex = dir_q.pop_front();
            chk($sformatf("row%0d_dout", i), 256'(ad), 256'(ex[10:3]));
            chk($sformatf("row%0d_vld", i), 256'(av), 256'(ex[2]));
            chk($sformatf("row%0d_ready", i), 256'(ar), 256'(ex[1]));
            chk($sformatf("row%0d_done", i), 256'(adn), 256'(ex[0]));
        end

        // Async reset in the middle of a HOLD=4 decode (counter at 2)
        do_reset();
        step3(1, 5, 0);
        chk("h4_first_dout", 256'(dout_c), 256'(8'h20));
        chk("h4_first_ready", 256'(rdy_c), 256'(0));
        step3(0, 0, 0);
        chk("h4_mid_dout", 256'(dout_c), 256'(8'h20));
        #2 rst = 1'b1;
        #1;
        chk("h4_arst_dout", 256'(dout_c), 256'(0));
        chk("h4_arst_vld", 256'(vld_c), 256'(0));
        chk("h4_arst_ready", 256'(rdy_c), 256'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        step3(1, 5, 0);
        chk("h4_after_dout", 256'(dout_c), 256'(8'h20));
        chk("h4_after_vld", 256'(vld_c), 256'(1));

        // Async reset in the middle of a HOLD=4 scan
        do_reset();
        step3(1, 1, 1);
        chk("s4_first_dout", 256'(dout_c), 256'(8'h02));
        repeat (4) step3(0, 0, 0);
        chk("s4_second_dout", 256'(dout_c), 256'(8'h04));
        chk("s4_second_ready", 256'(rdy_c), 256'(0));
        #2 rst = 1'b1;
        #1;
        chk("s4_arst_dout", 256'(dout_c), 256'(0));
        chk("s4_arst_vld", 256'(vld_c), 256'(0));
        chk("s4_arst_ready", 256'(rdy_c), 256'(1));
        chk("s4_arst_done", 256'(done_c), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        step3(1, 5, 0);
        chk("s4_after_dout", 256'(dout_c), 256'(8'h20));

        // Randomized runs on the extreme widths
        do_reset();
        run_rand(0, 5000);
        do_reset();
        run_rand(1, 5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
